// File: rtl/hazard_ctrl_if.sv
// Pipeline-control bundle between the core datapath and hazard_ctrl.
//   master : datapath side; drives hit/request/decode/EX info, receives controls
//   slave  : hazard_ctrl side; the mirror image
// Signals:
//   ihit, dhit, mem_req, halt_mem      fetch/data-memory/halt status
//   dc_rs, dc_rt, dc_uses_rt           decode-stage operand info
//   ex_memread, ex_rd                  EX-stage load info
//   BranchTaken, JumpSel               decode redirect info
//   pc_en, fetch_freeze, decode_freeze, decode_flush, execute_flush, halted
//   stall_count [CNT_W]                saturating stall-cycle counter
interface hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             ihit;
  logic             dhit;
  logic             mem_req;
  logic             halt_mem;
  logic [4:0]       dc_rs;
  logic [4:0]       dc_rt;
  logic             dc_uses_rt;
  logic             ex_memread;
  logic [4:0]       ex_rd;
  logic             BranchTaken;
  logic [1:0]       JumpSel;
  logic             pc_en;
  logic             fetch_freeze;
  logic             decode_freeze;
  logic             decode_flush;
  logic             execute_flush;
  logic             halted;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output ihit, dhit, mem_req, halt_mem, dc_rs, dc_rt, dc_uses_rt,
           ex_memread, ex_rd, BranchTaken, JumpSel,
    input  pc_en, fetch_freeze, decode_freeze, decode_flush, execute_flush,
           halted, stall_count
  );

  modport slave (
    input  ihit, dhit, mem_req, halt_mem, dc_rs, dc_rt, dc_uses_rt,
           ex_memread, ex_rd, BranchTaken, JumpSel,
    output pc_en, fetch_freeze, decode_freeze, decode_flush, execute_flush,
           halted, stall_count
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline sequencer for the 5-stage core. Resolves load-use hazards,
// data-memory waits, I-fetch misses, decode redirects and halt in one FSM,
// and drives the per-stage freeze/flush and PC-enable controls.
// Ports:
//   CLK  core clock, rising edge
//   RST  synchronous active-high reset
//   bus  hazard_ctrl_if.slave: status inputs in, pipeline controls out
// Outputs are Mealy (state + current inputs); stall_count is registered.
module hazard_ctrl #(
  parameter int LU_STALL_CYC = 1,
  parameter int CNT_W        = 16
) (
  input  logic         CLK,
  input  logic         RST,
  hazard_ctrl_if.slave bus
);
  localparam int LU_W = (LU_STALL_CYC > 1) ? $clog2(LU_STALL_CYC) : 1;

  typedef enum logic [1:0] {RUN, LU_STALL, DMEM_WAIT, HALT} state_t;

  state_t           state_q, state_d;
  logic [LU_W-1:0]  lu_cnt_q, lu_cnt_d;
  logic             redir_pend_q, redir_pend_d;
  logic [CNT_W-1:0] stall_count_q;

  logic pc_en, fetch_freeze, decode_freeze, decode_flush, execute_flush, halted;
  logic lu_haz, redir, do_run;

  assign lu_haz = bus.ex_memread && (bus.ex_rd != 5'd0) &&
                  ((bus.ex_rd == bus.dc_rs) ||
                   (bus.dc_uses_rt && (bus.ex_rd == bus.dc_rt)));
  assign redir  = bus.BranchTaken || (bus.JumpSel != 2'd0);

  always_comb begin
    state_d       = state_q;
    lu_cnt_d      = lu_cnt_q;
    redir_pend_d  = redir_pend_q;
    pc_en         = 1'b0;
    fetch_freeze  = 1'b0;
    decode_freeze = 1'b0;
    decode_flush  = 1'b0;
    execute_flush = 1'b0;
    halted        = 1'b0;
    do_run        = 1'b0;

    case (state_q)
      RUN: do_run = 1'b1;
      LU_STALL: begin
        // Halt and memory waits pre-empt the remaining bubbles.
        if (bus.halt_mem || (bus.mem_req && !bus.dhit)) begin
          do_run = 1'b1;
        end else begin
          fetch_freeze  = 1'b1;
          decode_freeze = 1'b1;
          execute_flush = 1'b1;
          lu_cnt_d      = lu_cnt_q - LU_W'(1);
          if (lu_cnt_q == LU_W'(1)) state_d = RUN;
        end
      end
      DMEM_WAIT: begin
        if (!bus.dhit) begin
          fetch_freeze  = 1'b1;
          decode_freeze = 1'b1;
        end else begin
          // Same-cycle release: the RUN decision applies on the dhit cycle.
          do_run = 1'b1;
        end
      end
      default: begin
        halted        = 1'b1;
        fetch_freeze  = 1'b1;
        decode_freeze = 1'b1;
      end
    endcase

    if (do_run) begin
      state_d = RUN;
      if (bus.halt_mem) begin
        state_d = HALT;
      end else if (bus.mem_req && !bus.dhit) begin
        state_d       = DMEM_WAIT;
        fetch_freeze  = 1'b1;
        decode_freeze = 1'b1;
      end else if (lu_haz) begin
        // A redirect arriving with the hazard is ignored here; decode
        // re-presents it once the bubble has been inserted.
        fetch_freeze  = 1'b1;
        decode_freeze = 1'b1;
        execute_flush = 1'b1;
        lu_cnt_d      = LU_W'(LU_STALL_CYC - 1);
        if (LU_STALL_CYC > 1) state_d = LU_STALL;
      end else if (!bus.ihit) begin
        fetch_freeze = 1'b1;
        decode_flush = 1'b1;
        if (redir) redir_pend_d = 1'b1;
      end else begin
        pc_en        = 1'b1;
        decode_flush = redir || redir_pend_q;
        redir_pend_d = 1'b0;
      end
    end

    if (RST) begin
      state_d       = RUN;
      lu_cnt_d      = '0;
      redir_pend_d  = 1'b0;
      pc_en         = 1'b0;
      fetch_freeze  = 1'b0;
      decode_freeze = 1'b0;
      halted        = 1'b0;
      decode_flush  = 1'b1;
      execute_flush = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q       <= RUN;
      lu_cnt_q      <= '0;
      redir_pend_q  <= 1'b0;
      stall_count_q <= '0;
    end else begin
      state_q      <= state_d;
      lu_cnt_q     <= lu_cnt_d;
      redir_pend_q <= redir_pend_d;
      // Saturating: holds at all-ones rather than wrapping.
      if ((state_q != HALT) && (fetch_freeze || decode_freeze) &&
          (stall_count_q != {CNT_W{1'b1}}))
        stall_count_q <= stall_count_q + CNT_W'(1);
    end
  end

  assign bus.pc_en         = pc_en;
  assign bus.fetch_freeze  = fetch_freeze;
  assign bus.decode_freeze = decode_freeze;
  assign bus.decode_flush  = decode_flush;
  assign bus.execute_flush = execute_flush;
  assign bus.halted        = halted;
  assign bus.stall_count   = stall_count_q;
endmodule
